// File: rtl/song_sequencer_if.sv
// Control, score-ROM and note-output signals of the autoplay sequencer.
// The slave modport is the sequencer's view; master is the driving side.
interface song_sequencer_if #(
  parameter int unsigned ADDR_W = 6
);
  logic              start;
  logic              stop;
  logic              pause;
  logic              loop_en;
  logic              beat_tick;
  logic [7:0]        rom_data;
  logic [ADDR_W-1:0] rom_addr;
  logic [3:0]        note;
  logic [7:0]        Led;
  logic              busy;
  logic              done;

  modport master (
    output start, stop, pause, loop_en, beat_tick, rom_data,
    input  rom_addr, note, Led, busy, done
  );

  modport slave (
    input  start, stop, pause, loop_en, beat_tick, rom_data,
    output rom_addr, note, Led, busy, done
  );
endinterface

// File: rtl/song_sequencer.sv
// Autoplay controller: walks a score in a synchronous ROM and presents one note per entry,
// timed in QUARTER_BEAT ticks, with an optional silent gap between notes.
module song_sequencer #(
  parameter int unsigned ADDR_W     = 6,
  parameter int unsigned GAP_CYCLES = 16,
  parameter int unsigned GAP_W      = 8
) (
  input logic             CLK,
  input logic             RESET,
  song_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StFetch = 3'd1,
    StLoad  = 3'd2,
    StPlay  = 3'd3,
    StGap   = 3'd4,
    StDone  = 3'd5
  } state_e;

  localparam logic [GAP_W-1:0] GapInit = GAP_W'(GAP_CYCLES);

  state_e            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_ptr, w_ptr_nxt;
  logic [3:0]        r_held, w_held_nxt;
  logic [3:0]        r_remain, w_remain_nxt;
  logic [GAP_W-1:0]  r_gap, w_gap_nxt;
  logic [3:0]        r_note, w_note_nxt;
  logic [7:0]        r_led, w_led_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;

  logic [3:0] w_code;
  logic [3:0] w_dur;

  assign w_code = bus.rom_data[7:4];
  assign w_dur  = bus.rom_data[3:0];

  // State register
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_state  <= StIdle;
      r_ptr    <= '0;
      r_held   <= '0;
      r_remain <= '0;
      r_gap    <= '0;
      r_note   <= '0;
      r_led    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_ptr    <= w_ptr_nxt;
      r_held   <= w_held_nxt;
      r_remain <= w_remain_nxt;
      r_gap    <= w_gap_nxt;
      r_note   <= w_note_nxt;
      r_led    <= w_led_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt  = r_state;
    w_ptr_nxt    = r_ptr;
    w_held_nxt   = r_held;
    w_remain_nxt = r_remain;
    w_gap_nxt    = r_gap;

    if (bus.stop && (r_state != StIdle)) begin
      w_state_nxt = StIdle;
      w_ptr_nxt   = '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (bus.start && !bus.stop) begin
            w_state_nxt = StFetch;
            w_ptr_nxt   = '0;
          end
        end
        StFetch: w_state_nxt = StLoad;
        StLoad: begin
          if (bus.rom_data == 8'h00) begin
            if (bus.loop_en) begin
              w_ptr_nxt   = '0;
              w_state_nxt = StFetch;
            end else begin
              w_state_nxt = StDone;
            end
          end else begin
            w_remain_nxt = (w_dur == 4'd0) ? 4'd1 : w_dur;
            w_held_nxt   = ((w_code >= 4'd1) && (w_code <= 4'd8)) ? w_code : 4'd0;
            w_state_nxt  = StPlay;
          end
        end
        StPlay: begin
          if (bus.beat_tick && !bus.pause) begin
            if (r_remain <= 4'd1) begin
              if (GAP_CYCLES == 0) begin
                w_ptr_nxt   = r_ptr + ADDR_W'(1);
                w_state_nxt = StFetch;
              end else begin
                w_gap_nxt   = GapInit;
                w_state_nxt = StGap;
              end
            end else begin
              w_remain_nxt = r_remain - 4'd1;
            end
          end
        end
        StGap: begin
          if (!bus.pause) begin
            if (r_gap <= GAP_W'(1)) begin
              w_ptr_nxt   = r_ptr + ADDR_W'(1);
              w_state_nxt = StFetch;
            end else begin
              w_gap_nxt = r_gap - GAP_W'(1);
            end
          end
        end
        StDone: begin
          w_ptr_nxt   = '0;
          w_state_nxt = StIdle;
        end
        default: begin
          w_ptr_nxt   = '0;
          w_state_nxt = StIdle;
        end
      endcase
    end
  end

  // Outputs are registered copies of what the next state presents; pause mutes the note only.
  always_comb begin
    w_note_nxt = '0;
    w_led_nxt  = '0;
    if ((w_state_nxt == StPlay) && !bus.pause) begin
      w_note_nxt = w_held_nxt;
    end
    if (w_note_nxt != 4'd0) begin
      w_led_nxt = 8'h80 >> (w_note_nxt - 4'd1);
    end
    w_busy_nxt = (w_state_nxt != StIdle);
    w_done_nxt = (w_state_nxt == StDone);
  end

  assign bus.rom_addr = r_ptr;
  assign bus.note     = r_note;
  assign bus.Led      = r_led;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;

endmodule

// File: tb/tb_song_sequencer.sv
// Bench for song_sequencer: synchronous score ROM model, note scoreboard counting beats per
// note, a table-driven score plus hand-timed sequences for pause, gap, loop, wrap and stop.
module tb_song_sequencer;
  localparam int GAP = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  song_sequencer_if #(.ADDR_W(6)) sif ();

  song_sequencer #(
    .ADDR_W    (6),
    .GAP_CYCLES(GAP),
    .GAP_W     (8)
  ) dut (
    .CLK  (clk),
    .RESET(rst_n),
    .bus  (sif.slave)
  );

  logic [7:0] rom [64];
  always @(posedge clk) sif.rom_data <= rom[sif.rom_addr];

  typedef struct {
    logic [3:0] note;
    logic [7:0] led;
    int         beats;
  } exp_t;

  typedef struct {
    logic [7:0] entry;
    logic [3:0] note;
    logic [7:0] led;
    int         beats;
  } vec_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  bit   sb_en = 1'b1;
  bit   in_note = 1'b0;
  bit   suspended = 1'b0;
  bit   p_prev = 1'b0;
  bit   wrap_seen = 1'b0;
  int   tick_cnt = 0;
  int   exp_beats = 0;
  int   done_cnt = 0;
  int   pops = 0;
  logic [5:0] prev_addr = '0;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    sif.beat_tick = 1'b1;
    step();
    sif.beat_tick = 1'b0;
  endtask

  task automatic pulse_start();
    sif.start = 1'b1;
    step();
    sif.start = 1'b0;
  endtask

  task automatic pulse_stop();
    sif.stop = 1'b1;
    step();
    sif.stop = 1'b0;
  endtask

  task automatic push(input logic [3:0] n, input logic [7:0] l, input int b);
    exp_t e;
    e.note = n; e.led = l; e.beats = b;
    exp_q.push_back(e);
  endtask

  // Cycles until note becomes non-zero, bounded.
  task automatic wait_note(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while ((sif.note == 4'd0) && (n < 80));
  endtask

  task automatic run_until_idle(input int period, input int bound);
    for (int i = 0; i < bound; i++) begin
      sif.beat_tick = ((i % period) == (period - 1));
      step();
      if (!sif.busy) break;
    end
    sif.beat_tick = 1'b0;
    check("idle_timeout", int'(sif.busy), 0);
  endtask

  task automatic run_until_pops(input int period, input int target, input int bound);
    for (int i = 0; i < bound; i++) begin
      sif.beat_tick = ((i % period) == (period - 1));
      step();
      if (pops >= target) break;
    end
    sif.beat_tick = 1'b0;
    check("pops_reached", int'(pops >= target), 1);
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 64; i++) rom[i] = 8'h00;
  endtask

  initial begin
    sif.start = 0; sif.stop = 0; sif.pause = 0; sif.loop_en = 0; sif.beat_tick = 0;
    clear_rom();
    fork
      begin : monitor
        exp_t e;
        forever begin
          @(negedge clk);
          if (sif.done) done_cnt++;
          if ((prev_addr == 6'd63) && (sif.rom_addr == 6'd0)) wrap_seen = 1'b1;
          prev_addr = sif.rom_addr;
          if (sb_en) begin
            if (!in_note && (sif.note != 4'd0)) begin
              if (suspended) begin
                suspended = 1'b0;
              end else if (exp_q.size() == 0) begin
                check("unexpected_note", int'(sif.note), 0);
              end else begin
                e = exp_q.pop_front();
                check("sb_note", int'(sif.note), int'(e.note));
                check("sb_led", int'(sif.Led), int'(e.led));
                exp_beats = e.beats;
                tick_cnt = 0;
                pops++;
              end
              in_note = 1'b1;
            end else if (in_note && (sif.note == 4'd0)) begin
              in_note = 1'b0;
              if (p_prev) suspended = 1'b1;
              else check("sb_beats", tick_cnt, exp_beats);
            end
            // Counted now, consumed by the DUT at the coming edge.
            if (in_note && sif.beat_tick && !sif.pause) tick_cnt++;
          end else begin
            in_note = 1'b0;
            suspended = 1'b0;
          end
          p_prev = sif.pause;
        end
      end
      begin : main
        vec_t vecs[13];
        int   n, d0, base;
        vecs[0]  = '{8'h32, 4'd3, 8'h20, 2};
        vecs[1]  = '{8'h51, 4'd5, 8'h08, 1};
        vecs[2]  = '{8'h10, 4'd1, 8'h80, 1};
        vecs[3]  = '{8'h81, 4'd8, 8'h01, 1};
        vecs[4]  = '{8'h24, 4'd2, 8'h40, 4};
        vecs[5]  = '{8'h43, 4'd4, 8'h10, 3};
        vecs[6]  = '{8'h62, 4'd6, 8'h04, 2};
        vecs[7]  = '{8'h71, 4'd7, 8'h02, 1};
        vecs[8]  = '{8'hA3, 4'd0, 8'h00, 3};
        vecs[9]  = '{8'h01, 4'd0, 8'h00, 1};
        vecs[10] = '{8'hF2, 4'd0, 8'h00, 2};
        vecs[11] = '{8'h2F, 4'd2, 8'h40, 15};
        vecs[12] = '{8'h9F, 4'd0, 8'h00, 15};

        // Reset state
        repeat (3) step();
        check("rst_note", int'(sif.note), 0);
        check("rst_led", int'(sif.Led), 0);
        check("rst_busy", int'(sif.busy), 0);
        check("rst_done", int'(sif.done), 0);
        check("rst_addr", int'(sif.rom_addr), 0);
        rst_n = 1'b1;
        step();

        // Reset during PLAY
        sb_en = 1'b0;
        rom[0] = 8'h34; rom[1] = 8'h00;
        pulse_start(); step(); step();
        check("mid_note", int'(sif.note), 3);
        d0 = done_cnt;
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        check("mrst_note", int'(sif.note), 0);
        check("mrst_led", int'(sif.Led), 0);
        check("mrst_busy", int'(sif.busy), 0);
        check("mrst_addr", int'(sif.rom_addr), 0);
        repeat (3) step();
        check("mrst_no_done", done_cnt - d0, 0);
        sb_en = 1'b1;

        // Table-driven score
        clear_rom();
        foreach (vecs[i]) begin
          rom[i] = vecs[i].entry;
          if (vecs[i].note != 4'd0) push(vecs[i].note, vecs[i].led, vecs[i].beats);
        end
        d0 = done_cnt;
        pulse_start();
        run_until_idle(5, 4000);
        check("tbl_queue", exp_q.size(), 0);
        check("tbl_done", done_cnt - d0, 1);

        // Basic score with exact timing
        clear_rom();
        rom[0] = 8'h32; rom[1] = 8'h51; rom[2] = 8'h00;
        push(4'd3, 8'h20, 2); push(4'd5, 8'h08, 1);
        d0 = done_cnt;
        pulse_start(); step();
        check("load_note", int'(sif.note), 0);
        step();
        check("first_note", int'(sif.note), 3);
        check("first_led", int'(sif.Led), 32'h20);
        tick();
        check("held_note", int'(sif.note), 3);
        repeat (3) step();
        tick();
        check("note_end", int'(sif.note), 0);
        wait_note(n);
        check("gap_len", n, GAP + 2);
        check("second_note", int'(sif.note), 5);
        check("second_led", int'(sif.Led), 32'h08);
        tick();
        check("second_end", int'(sif.note), 0);
        run_until_idle(1000, 200);
        check("basic_done", done_cnt - d0, 1);
        check("basic_queue", exp_q.size(), 0);

        // Rest entry holds silence for its full duration
        clear_rom();
        rom[0] = 8'hA3; rom[1] = 8'h11; rom[2] = 8'h00;
        push(4'd1, 8'h80, 1);
        pulse_start(); step(); step();
        tick(); step(); tick(); step();
        repeat (25) step();
        check("rest_silent", int'(sif.note), 0);
        tick();
        wait_note(n);
        check("rest_len", n, GAP + 2);
        run_until_idle(4, 300);

        // Pause mid-note
        clear_rom();
        rom[0] = 8'h83; rom[1] = 8'h00;
        push(4'd8, 8'h01, 3);
        pulse_start(); step(); step();
        check("p_note", int'(sif.note), 8);
        tick(); step();
        sif.pause = 1'b1;
        step();
        check("p_mute_note", int'(sif.note), 0);
        check("p_mute_led", int'(sif.Led), 0);
        repeat (3) begin tick(); step(); end
        check("p_still_mute", int'(sif.note), 0);
        check("p_busy", int'(sif.busy), 1);
        sif.pause = 1'b0;
        step();
        check("p_restore", int'(sif.note), 8);
        check("p_restore_led", int'(sif.Led), 1);
        step(); tick();
        check("p_one_left", int'(sif.note), 8);
        step(); tick();
        check("p_finished", int'(sif.note), 0);
        run_until_idle(1000, 200);
        check("p_queue", exp_q.size(), 0);

        // Loop over three passes plus the start of a fourth
        clear_rom();
        rom[0] = 8'h32; rom[1] = 8'h51; rom[2] = 8'h00;
        sif.loop_en = 1'b1;
        repeat (3) begin push(4'd3, 8'h20, 2); push(4'd5, 8'h08, 1); end
        push(4'd3, 8'h20, 2);
        d0 = done_cnt;
        base = pops;
        pulse_start();
        run_until_pops(4, base + 7, 3000);
        check("loop_addr", int'(sif.rom_addr), 0);
        sb_en = 1'b0;
        pulse_stop();
        check("loop_stop_busy", int'(sif.busy), 0);
        check("loop_no_done", done_cnt - d0, 0);
        check("loop_queue", exp_q.size(), 0);
        sif.loop_en = 1'b0;
        step();
        sb_en = 1'b1;

        // 64 entries without a marker: address wraps 63 -> 0
        for (int i = 0; i < 64; i++) rom[i] = {4'((i % 8) + 1), 4'h1};
        for (int i = 0; i < 65; i++) push(4'((i % 8) + 1), 8'h80 >> (i % 8), 1);
        base = pops;
        pulse_start();
        run_until_pops(3, base + 65, 5000);
        check("wrap_seen", int'(wrap_seen), 1);
        sb_en = 1'b0;
        pulse_stop();
        check("wrap_stop_busy", int'(sif.busy), 0);
        step();
        sb_en = 1'b1;

        // Stop during GAP
        clear_rom();
        rom[0] = 8'h11; rom[1] = 8'h21; rom[2] = 8'h00;
        push(4'd1, 8'h80, 1); push(4'd2, 8'h40, 1);
        pulse_start(); step(); step();
        tick();
        wait_note(n);
        check("sg_note2", int'(sif.note), 2);
        tick();
        repeat (5) step();
        check("sg_gap_addr", int'(sif.rom_addr), 1);
        d0 = done_cnt;
        pulse_stop();
        check("sg_busy", int'(sif.busy), 0);
        check("sg_addr", int'(sif.rom_addr), 0);
        check("sg_note", int'(sif.note), 0);
        repeat (3) step();
        check("sg_no_done", done_cnt - d0, 0);

        // start and stop together while idle
        sif.start = 1'b1; sif.stop = 1'b1;
        step();
        sif.start = 1'b0; sif.stop = 1'b0;
        check("ss_busy", int'(sif.busy), 0);
        repeat (5) step();
        check("ss_busy_later", int'(sif.busy), 0);
        check("ss_addr", int'(sif.rom_addr), 0);

        // start while playing is ignored
        clear_rom();
        rom[0] = 8'h11; rom[1] = 8'h24; rom[2] = 8'h00;
        push(4'd1, 8'h80, 1); push(4'd2, 8'h40, 4);
        d0 = done_cnt;
        pulse_start(); step(); step();
        tick();
        wait_note(n);
        pulse_start();
        check("sp_note", int'(sif.note), 2);
        check("sp_addr", int'(sif.rom_addr), 1);
        run_until_idle(4, 500);
        check("sp_done", done_cnt - d0, 1);
        check("sp_queue", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
    join_any
  end
endmodule

// File: doc/song_sequencer.md
Name: song_sequencer

Overview:
- Autoplay controller for the piano note datapath: steps through a score held in an external synchronous ROM.
- On each QUARTER_BEAT tick it presents the current 4-bit note code to the frequency mux, and drives a one-hot Led pattern matching the lesson-mode switch layout.
- Supports start/stop, pause, looping and a configurable silent articulation gap between notes.

Parameters:
ADDR_W, 6, score ROM address width (up to 64 entries)
GAP_CYCLES, 16, CLK cycles of silence inserted after each note; 0 disables the gap
GAP_W, 8, width of gap counter (GAP_CYCLES must be < 2^GAP_W)

Ports:
CLK  input  1  system clock
RESET  input  1  synchronous active-low reset
start  input  1  one-cycle pulse; begins playback from address 0 when idle
stop  input  1  one-cycle pulse; abort playback
pause  input  1  level; freezes playback and mutes output while high
loop_en  input  1  level; restart at address 0 on end-of-score instead of finishing
beat_tick  input  1  one-cycle QUARTER_BEAT pulse from clockManager
rom_data  input  8  score entry: [7:4] note code, [3:0] duration in quarter beats
rom_addr  output  ADDR_W  score ROM address
note  output  4  note code: 0 none, 1 C4, 2 D, 3 E, 4 F, 5 G, 6 A, 7 B, 8 C5
Led  output  8  one-hot of note: C4 -> bit7 ... C5 -> bit0; 0 when note=0
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse when score ends without loop

Behaviour:
- Reset (RESET=0 at posedge CLK): state IDLE, rom_addr=0, note=0, Led=0, busy=0, done=0, all counters 0. Reset mid-playback aborts immediately, with no done pulse.
- All outputs are registered. Led is a registered decode of the next note value, updated in the same cycle as note.
- ROM: rom_data is valid the cycle after rom_addr changes. rom_addr equals the internal pointer at all times.
- States: IDLE, FETCH, LOAD, PLAY, GAP, DONE.
- IDLE: note=0. start=1 -> FETCH with pointer=0.
- FETCH: one cycle waiting for ROM latency; always -> LOAD.
- LOAD: decodes rom_data.
  - rom_data==0x00 is the end marker. With loop_en=1: pointer=0, -> FETCH. With loop_en=0: -> DONE.
  - Otherwise: remaining = duration, where duration 0 is treated as 1. note = field if field is 1..8, else 0 (rest; codes 0 and 9..15 are rests). -> PLAY.
- PLAY: each beat_tick with pause=0 decrements remaining.
  - When beat_tick arrives with remaining==1: note=0, and -> GAP with gap counter=GAP_CYCLES (or pointer+1 and -> FETCH if GAP_CYCLES==0).
  - A beat_tick coinciding with the LOAD->PLAY transition cycle is not counted.
- GAP: note=0. The counter decrements every cycle while pause=0. At 1 -> pointer+1, -> FETCH.
- DONE: done=1 for exactly one cycle, note=0, pointer=0, -> IDLE. busy is still 1 in DONE.
- Pointer increment wraps modulo 2^ADDR_W, with no end marker required at the wrap.
- pause=1:
  - note and Led are forced to 0.
  - beat_tick is ignored and the gap counter holds.
  - FETCH/LOAD proceed normally; LOAD's note value is held internally and presented when pause drops.
  - The Led/note restore happens on the first cycle with pause=0.
- stop=1 (any state except IDLE): -> IDLE, pointer=0, note=0, Led=0, no done pulse. Takes effect on that edge.
- Priority per edge: RESET > stop > start > normal sequencing.
  - start and stop in the same cycle: stop wins and the block stays IDLE.
  - start while busy: ignored.
- End-of-score: a loop_en change is sampled only in LOAD at the marker.

Test Plan:
- Reset: hold RESET=0 for 3 cycles during PLAY -> next cycle note=0, Led=0x00, busy=0, rom_addr=0, done never pulses.
- Basic score {0x32, 0x51, 0x00}, GAP_CYCLES=16, loop_en=0:
  - start -> note=3 (E), Led=0x20 for 2 beat_ticks, then 16 cycles of note=0.
  - Then note=5 (G), Led=0x08 for 1 tick, then gap, then a single done pulse, then busy=0.
- Loop: same score with loop_en=1 -> after the 0x00 marker rom_addr returns to 0 and note=3 again; done never asserts over 3 passes.
- Boundaries:
  - Entry 0x10 (C4, duration 0) -> plays exactly 1 beat.
  - Entry 0xA3 (code 10) -> note=0 for 3 beats, then next entry.
  - A 64-entry score with no marker -> rom_addr wraps 63 -> 0.
- Pause mid-note: note=8, remaining=2, pause=1 across 3 beat_ticks -> note=0, Led=0, state held. After pause=0, note=8 for exactly 2 further ticks.
- Stop/start collisions:
  - stop during GAP -> next cycle IDLE, rom_addr=0, done=0.
  - start and stop asserted together in IDLE -> remains IDLE.
  - start during PLAY -> no effect on rom_addr or note.
